// File: rtl/camera_ddr_pkg.sv
// Shared constants and FSM encoding for the camera-to-DDR write burst path.
package camera_ddr_pkg;

   localparam int unsigned DEF_BURST_LEN    = 8;
   localparam int unsigned DEF_FIFO_DEPTH   = 32;
   localparam int unsigned DEF_ADDR_W       = 28;
   localparam logic [27:0] DEF_FRAME_STRIDE = 28'h080_0000;
   localparam int unsigned BYTES_PER_WORD   = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMD  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      CMD  = ST_CMD,
      DATA = ST_DATA
   } wr_state_e;

endpackage

// File: rtl/camera_wr_fifo.sv
// Single-clock first-word-fall-through word buffer with extra-MSB pointers and a
// frame-start rewind that drops the uncommitted partial burst.
module camera_wr_fifo #(
   parameter int unsigned DEPTH     = 32,
   parameter int unsigned BURST_LEN = 8,
   parameter int unsigned WIDTH     = 64
) (
   input  logic                     camera_pclk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_word,
   input  logic                     rewind_partial,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_word,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LB = $clog2(BURST_LEN);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE      = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      wr_base;
   logic             wr_ok;

   // The rewind applies before this cycle's write, so a word arriving with a
   // frame start lands as word 0 of the new frame.
   always_comb begin
      wr_base = wr_ptr;
      if (rewind_partial) begin
         wr_base[LB-1:0] = '0;
      end
   end

   assign full      = (wr_base - rd_ptr) == FULL_CNT;
   assign wr_ok     = wr_en && !full;
   assign occupancy = wr_ptr - rd_ptr;
   assign rd_word   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge camera_pclk) begin
      if (wr_ok) begin
         mem[wr_base[AW-1:0]] <= wr_word;
      end
   end

   always_ff @(posedge camera_pclk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ok ? (wr_base + ONE) : wr_base;
         if (rd_en) begin
            rd_ptr <= rd_ptr + ONE;
         end
      end
   end

endmodule

// File: rtl/camera_ddr_wr_burst.sv
// Packs captured 64-bit words into fixed-length DDR write bursts and generates
// frame-slot based byte addresses for each burst command.
module camera_ddr_wr_burst
   import camera_ddr_pkg::*;
#(
   parameter int unsigned       BURST_LEN    = DEF_BURST_LEN,
   parameter int unsigned       FIFO_DEPTH   = DEF_FIFO_DEPTH,
   parameter int unsigned       ADDR_W       = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'(DEF_FRAME_STRIDE)
) (
   input  logic              camera_pclk,
   input  logic              reset,
   input  logic              ddr_wren,
   input  logic [63:0]       ddr_data_camera,
   input  logic              ddr_addr_wr_set,
   input  logic [1:0]        frame_switch,
   output logic              wr_cmd_valid,
   input  logic              wr_cmd_ready,
   output logic [ADDR_W-1:0] wr_cmd_addr,
   output logic [63:0]       wr_data,
   output logic              wr_data_valid,
   input  logic              wr_data_ready,
   output logic              wr_data_last,
   output logic              overflow_err,
   output logic              frame_oversize,
   output logic [15:0]       burst_count
);

   localparam int unsigned       AW          = $clog2(FIFO_DEPTH);
   localparam int unsigned       LB          = $clog2(BURST_LEN);
   localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * BYTES_PER_WORD);
   localparam logic [AW:0]       BURST_WORDS = (AW+1)'(BURST_LEN);
   localparam logic [LB-1:0]     LAST_BEAT   = LB'(BURST_LEN - 1);

   wr_state_e         state;
   logic              set_q;
   logic              frame_start;
   logic              clear_pending;
   logic [1:0]        frame_sel;
   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] offset_inc;
   logic [ADDR_W-1:0] next_addr;
   logic              offset_wrap;
   logic [LB-1:0]     beat;
   logic              fifo_full;
   logic [AW:0]       occupancy;
   logic [63:0]       fifo_word;
   logic              cmd_hs;
   logic              data_hs;
   logic              last_hs;

   assign frame_start = ddr_addr_wr_set ^ set_q;
   assign cmd_hs      = (state == CMD) && wr_cmd_ready;
   assign data_hs     = (state == DATA) && wr_data_ready;
   assign last_hs     = data_hs && (beat == LAST_BEAT);
   assign offset_inc  = offset + BURST_BYTES;
   assign offset_wrap = offset_inc >= FRAME_STRIDE;
   // A frame start seen in IDLE takes effect on the very command it coincides with.
   assign next_addr   = frame_start ? (ADDR_W'(frame_switch) * FRAME_STRIDE)
                                    : (ADDR_W'(frame_sel) * FRAME_STRIDE + offset);

   camera_wr_fifo #(
      .DEPTH     (FIFO_DEPTH),
      .BURST_LEN (BURST_LEN),
      .WIDTH     (64)
   ) u_fifo (
      .camera_pclk    (camera_pclk),
      .reset          (reset),
      .wr_en          (ddr_wren),
      .wr_word        (ddr_data_camera),
      .rewind_partial (frame_start),
      .rd_en          (data_hs),
      .rd_word        (fifo_word),
      .full           (fifo_full),
      .occupancy      (occupancy)
   );

   always_ff @(posedge camera_pclk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         set_q          <= 1'b0;
         frame_sel      <= '0;
         offset         <= '0;
         clear_pending  <= 1'b0;
         beat           <= '0;
         wr_cmd_addr    <= '0;
         burst_count    <= '0;
         overflow_err   <= 1'b0;
         frame_oversize <= 1'b0;
      end else begin
         set_q <= ddr_addr_wr_set;
         if (ddr_wren && fifo_full) begin
            overflow_err <= 1'b1;
         end
         if (frame_start) begin
            frame_sel <= frame_switch;
         end
         case (state)
            IDLE: begin
               if (frame_start) begin
                  offset <= '0;
               end
               if (occupancy >= BURST_WORDS) begin
                  state       <= CMD;
                  wr_cmd_addr <= next_addr;
               end
            end
            CMD: begin
               if (frame_start) begin
                  clear_pending <= 1'b1;
               end
               if (cmd_hs) begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (data_hs) begin
                  beat <= beat + LB'(1);
               end
               // Offset clears requested mid-burst are applied once the burst retires.
               if (last_hs) begin
                  state         <= IDLE;
                  clear_pending <= 1'b0;
                  if (clear_pending || frame_start) begin
                     offset <= '0;
                  end else if (offset_wrap) begin
                     offset         <= '0;
                     frame_oversize <= 1'b1;
                  end else begin
                     offset <= offset_inc;
                  end
               end else if (frame_start) begin
                  clear_pending <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
         if (frame_start) begin
            burst_count <= '0;
         end else if (last_hs) begin
            burst_count <= burst_count + 16'd1;
         end
      end
   end

   assign wr_cmd_valid  = (state == CMD);
   assign wr_data_valid = (state == DATA);
   assign wr_data       = wr_data_valid ? fifo_word : '0;
   assign wr_data_last  = wr_data_valid && (beat == LAST_BEAT);

endmodule
